br_mux_arb: RTL and testbench



---
 rtl/br_mux_pkg.sv | 32 +++
 rtl/br_rr_pick.sv | 22 ++
 rtl/br_mux_arb.sv | 96 +++++++++
 tb/tb_br_mux_arb.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/br_mux_pkg.sv
// Shared definitions for the br_* mux/arbiter family: mode encodings,
// counter width and a reusable rotate-priority pick function.
package br_mux_pkg;

    localparam logic        MODE_FIXED = 1'b0;
    localparam logic        MODE_RR    = 1'b1;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned MAX_N      = 16;
    localparam int unsigned IDX_W      = 4;

    // Returns {found, index}: first set bit of valid[n-1:0] scanning from ptr upward with wrap.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [MAX_N-1:0] valid,
        input logic [IDX_W-1:0] ptr,
        input int unsigned      n
    );
        logic [IDX_W:0] res;
        int unsigned    idx;
        res = '0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                idx = 32'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (!res[IDX_W] && valid[idx[IDX_W-1:0]]) begin
                    res = {1'b1, idx[IDX_W-1:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/br_rr_pick.sv
// Combinational rotate-priority encoder: first valid channel at or after ptr, wrapping mod N.
module br_rr_pick
    import br_mux_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] idx
);

    logic [IDX_W:0] pick;

    always_comb begin
        pick  = rr_pick(MAX_N'(valid), IDX_W'(ptr), N);
        found = pick[IDX_W];
        idx   = SW'(pick);
    end

endmodule

// File: rtl/br_mux_arb.sv
// N-channel W-bit valid/ready mux with fixed-select or round-robin arbitration
// and one registered output slot. Define BR_MUX_ARB_GRANT_CNT_EN for per-channel grant counters.
module br_mux_arb
    import br_mux_pkg::*;
#(
    parameter  int unsigned W  = 4,
    parameter  int unsigned N  = 4,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_ch
`ifdef BR_MUX_ARB_GRANT_CNT_EN
    ,
    output logic [N*CNT_W-1:0] grant_cnt,
    input  logic               cnt_clr
`endif
);

    localparam int unsigned NP = 2**SW;

    logic [SW-1:0] ptr;
    logic [NP-1:0] valid_ext;
    logic          rr_found;
    logic [SW-1:0] rr_idx;
    logic          grant;
    logic [SW-1:0] g;
    logic          load_en;
    logic          xfer;

    br_rr_pick #(.N(N)) u_pick (
        .valid (in_valid),
        .ptr   (ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // Zero-padded so an out-of-range sel simply sees no valid.
    assign valid_ext = NP'(in_valid);
    assign load_en   = !out_valid || out_ready;

    always_comb begin
        grant    = 1'b0;
        g        = '0;
        in_ready = '0;
        if (mode == MODE_RR) begin
            grant = rr_found;
            g     = rr_idx;
        end else begin
            grant = valid_ext[sel];
            g     = sel;
        end
        xfer = rst_n && grant && load_en;
        if (xfer) in_ready = N'(1) << g;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (xfer) begin
            out_data  <= in_data[g*W +: W];
            out_ch    <= g;
            out_valid <= 1'b1;
            ptr       <= (g == SW'(N-1)) ? '0 : g + SW'(1);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BR_MUX_ARB_GRANT_CNT_EN
    // Saturating per-channel transfer counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (in_ready[i] && grant_cnt[i*CNT_W +: CNT_W] != '1) begin
                    grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_br_mux_arb.sv
// Scoreboard bench for br_mux_arb (W=4, N=4): directed vectors push expected words,
// a monitor pops and compares each word the DUT hands to the consumer.
module tb_br_mux_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
`ifdef BR_MUX_ARB_GRANT_CNT_EN
    logic [63:0] grant_cnt;
    logic        cnt_clr = 1'b0;
`endif

    int          n_checks = 0;
    int          n_err    = 0;
    logic [5:0]  sb_q[$];

    always #5 clk = ~clk;

    br_mux_arb #(.W(4), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
`ifdef BR_MUX_ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt),
        .cnt_clr   (cnt_clr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus after negedge, check in_ready, record expected word.
    task automatic step(input logic r, input logic [3:0] v, input logic [15:0] d,
                        input logic m, input logic [1:0] s, input logic ordy,
                        input logic [3:0] exp_ir, input logic push,
                        input logic [3:0] ed, input logic [1:0] ec);
        @(negedge clk);
        rst_n = r; in_valid = v; in_data = d; mode = m; sel = s; out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        if (push) sb_q.push_back({ed, ec});
    endtask

    // Monitor: every word accepted by the consumer must match the scoreboard head.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", {26'd0, out_data, out_ch}, 32'h3f);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e[5:2]));
                    chk("out_ch",   32'(out_ch),   32'(e[1:0]));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = '0; in_data = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;

        // Reset: in_ready stays low even with every channel valid.
        step(0, 4'b1111, 16'h4321, 1, 0, 1, 4'b0000, 0, 0, 0);
        step(0, 4'b1111, 16'h4321, 1, 0, 1, 4'b0000, 0, 0, 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_ch",    32'(out_ch),    0);

        // Fixed select: sel=2 grants ch2; sel pointing at an idle channel grants nothing.
        step(1, 4'b0100, 16'h0A00, 0, 2, 1, 4'b0100, 1, 4'hA, 2);
        step(1, 4'b0100, 16'h0A00, 0, 1, 1, 4'b0000, 0, 0, 0);
        chk("fix_latency_valid", 32'(out_valid), 1);
        step(1, 4'b1000, 16'h5000, 0, 3, 1, 4'b1000, 1, 4'h5, 3);

        // Round-robin, all valid, from ptr=0: one word per cycle in channel order.
        for (int k = 0; k < 8; k++) begin
            step(1, 4'b1111, 16'h4321, 1, 0, 1, 4'(1 << (k % 4)), 1, 4'((k % 4) + 1), 2'(k % 4));
        end

        // Backpressure: held word (4,3) stays put and nothing is granted.
        for (int k = 0; k < 3; k++) begin
            step(1, 4'b1111, 16'h4321, 1, 0, 0, 4'b0000, 0, 0, 0);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data",  32'(out_data),  4);
            chk("stall_ch",    32'(out_ch),    3);
        end
        step(1, 4'b1111, 16'h4321, 1, 0, 1, 4'b0001, 1, 4'h1, 0);
        step(1, 4'b1111, 16'h4321, 1, 0, 1, 4'b0010, 1, 4'h2, 1);
        step(1, 4'b0000, 16'h4321, 1, 0, 1, 4'b0000, 0, 0, 0);

        // Wrap and sparse: ptr=3 after fixed ch2; only ch1 valid; then ch3 beats ch0.
        step(1, 4'b0100, 16'h0700, 0, 2, 1, 4'b0100, 1, 4'h7, 2);
        step(1, 4'b0010, 16'h0090, 1, 0, 1, 4'b0010, 1, 4'h9, 1);
        step(1, 4'b1001, 16'hB00C, 1, 0, 1, 4'b1000, 1, 4'hB, 3);
        step(1, 4'b1001, 16'hB00C, 1, 0, 1, 4'b0001, 1, 4'hC, 0);

        // Mid-stream reset drops the held (C,0) word; ptr was 1 before reset.
        step(1, 4'b0000, 16'h0000, 1, 0, 0, 4'b0000, 0, 0, 0);
        chk("pre_rst_valid", 32'(out_valid), 1);
        step(0, 4'b1111, 16'h4321, 1, 0, 0, 4'b0000, 0, 0, 0);
        void'(sb_q.pop_front());
        step(1, 4'b0101, 16'h0E06, 1, 0, 1, 4'b0001, 1, 4'h6, 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data",  32'(out_data),  0);
        chk("mid_rst_ch",    32'(out_ch),    0);
        step(1, 4'b0000, 16'h0000, 1, 0, 1, 4'b0000, 0, 0, 0);

`ifdef BR_MUX_ARB_GRANT_CNT_EN
        // Five ch1 transfers counted, then clear beats a simultaneous transfer.
        for (int k = 0; k < 5; k++) begin
            step(1, 4'b0010, 16'h0030, 0, 1, 1, 4'b0010, 1, 4'h3, 1);
        end
        step(1, 4'b0000, 16'h0000, 0, 1, 1, 4'b0000, 0, 0, 0);
        chk("cnt_ch1_5", 32'(grant_cnt[31:16]), 5);
        cnt_clr = 1'b1;
        step(1, 4'b0010, 16'h0030, 0, 1, 1, 4'b0010, 1, 4'h3, 1);
        @(negedge clk);
        cnt_clr = 1'b0;
        in_valid = '0;
        #1;
        chk("cnt_ch1_clr", 32'(grant_cnt[31:16]), 0);
`endif

        step(1, 4'b0000, 16'h0000, 1, 0, 1, 4'b0000, 0, 0, 0);
        step(1, 4'b0000, 16'h0000, 1, 0, 1, 4'b0000, 0, 0, 0);
        chk("drained_valid", 32'(out_valid), 0);
        chk("scoreboard_empty", 32'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
